// File: rtl/line_dma_pkg.sv
// Shared types and constants for the line-scan DMA writer.
// Word addresses and offsets count 128-bit beats, not bytes.
package line_dma_pkg;

    localparam int DATA_W     = 128;
    localparam int BEAT_BYTES = 16;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_OVERFLOW = 2;
    localparam int STAT_CFG_ERR  = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_BURST,
        S_FLUSH
    } dma_state_t;

    function automatic logic [31:0] umin(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/line_dma_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible before it is popped.
// Push is ignored when full and pop is ignored when empty.
module line_dma_fifo
    import line_dma_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = DATA_W
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic [AW:0]   o_fill,
    output logic          o_full,
    output logic          o_empty
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_fill  = r_count;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/line_dma_writer.sv
// Avalon-MM burst write master: buffers pixel words and writes them as
// bursts into a one-shot or ring buffer in SDRAM, reporting via status/irq.
module line_dma_writer
    import line_dma_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int BURST_W   = 8,
    parameter int ADDR_W    = 28,
    parameter int FIFO_AW   = 5
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_cfg_ring,
    input  logic [31:0]        i_cfg_base,
    input  logic [31:0]        i_cfg_size,
    input  logic [DATA_W-1:0]  i_px_data,
    input  logic               i_px_valid,
    output logic [ADDR_W-1:0]  o_av_address,
    output logic [BURST_W-1:0] o_av_burstcount,
    output logic               o_av_write,
    output logic [DATA_W-1:0]  o_av_writedata,
    output logic [15:0]        o_av_byteenable,
    input  logic               i_av_waitrequest,
    output logic [31:0]        o_status,
    output logic               o_irq
);

    dma_state_t         r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_size;
    logic [ADDR_W-1:0]  r_offset;
    logic [ADDR_W-1:0]  r_addr;
    logic [BURST_W-1:0] r_bcnt;
    logic [BURST_W-1:0] r_beats_left;
    logic               r_ring;
    logic               r_done;
    logic               r_ovf;
    logic               r_cfg_err;
    logic               r_stop_pend;
    logic               r_write;
    logic               r_irq;

    logic [DATA_W-1:0]  w_head;
    logic [FIFO_AW:0]   w_fill;
    logic [FIFO_AW:0]   w_fill_after;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_drop;
    logic               w_accept;
    logic               w_last_beat;
    logic               w_wrap;
    logic               w_stop_any;
    logic [ADDR_W-1:0]  w_cfg_base_w;
    logic [ADDR_W-1:0]  w_cfg_size_w;
    logic [ADDR_W-1:0]  w_fill_ext;
    logic [ADDR_W-1:0]  w_remain;
    logic [ADDR_W-1:0]  w_len_run;
    logic [ADDR_W-1:0]  w_len_flush;
    logic [ADDR_W-1:0]  w_next_addr;
    logic [ADDR_W-1:0]  w_offset_inc;

    assign w_cfg_base_w = ADDR_W'(i_cfg_base >> $clog2(BEAT_BYTES));
    assign w_cfg_size_w = ADDR_W'(i_cfg_size >> $clog2(BEAT_BYTES));

    assign w_push       = i_px_valid && (r_state != S_IDLE) && !w_full;
    assign w_drop       = i_px_valid && (r_state != S_IDLE) && w_full;
    assign w_accept     = r_write && !i_av_waitrequest;
    assign w_last_beat  = w_accept && (r_beats_left == BURST_W'(1));
    assign w_fill_after = w_fill + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_accept);

    assign w_fill_ext   = ADDR_W'(w_fill);
    assign w_remain     = r_size - r_offset;
    assign w_len_run    = ADDR_W'(umin(32'(w_remain), 32'(MAX_BURST)));
    assign w_len_flush  = ADDR_W'(umin(32'(w_len_run), 32'(w_fill_ext)));
    assign w_next_addr  = r_base + r_offset;
    assign w_offset_inc = r_offset + ADDR_W'(r_bcnt);
    assign w_wrap       = (w_offset_inc == r_size);
    assign w_stop_any   = r_stop_pend || i_stop;

    line_dma_fifo #(
        .AW(FIFO_AW),
        .DW(DATA_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (w_push),
        .i_data    (i_px_data),
        .i_pop     (w_accept),
        .o_head    (w_head),
        .o_fill    (w_fill),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_size       <= '0;
            r_offset     <= '0;
            r_addr       <= '0;
            r_bcnt       <= '0;
            r_beats_left <= '0;
            r_ring       <= 1'b0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_write      <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_base      <= w_cfg_base_w;
                        r_size      <= w_cfg_size_w;
                        r_ring      <= i_cfg_ring;
                        r_offset    <= '0;
                        r_done      <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_stop_pend <= 1'b0;
                        r_cfg_err   <= (w_cfg_size_w == '0);
                        if (w_cfg_size_w != '0) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (i_stop) begin
                        r_stop_pend <= 1'b1;
                        r_state     <= S_FLUSH;
                    end else if (w_fill_ext >= w_len_run) begin
                        r_write      <= 1'b1;
                        r_addr       <= w_next_addr;
                        r_bcnt       <= BURST_W'(w_len_run);
                        r_beats_left <= BURST_W'(w_len_run);
                        r_state      <= S_BURST;
                    end
                end
                S_FLUSH: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_irq   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_write      <= 1'b1;
                        r_addr       <= w_next_addr;
                        r_bcnt       <= BURST_W'(w_len_flush);
                        r_beats_left <= BURST_W'(w_len_flush);
                        r_state      <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (i_stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_accept) begin
                        r_beats_left <= r_beats_left - BURST_W'(1);
                    end
                    // A one-shot buffer keeps its final offset so status shows words written.
                    if (w_last_beat) begin
                        r_write  <= 1'b0;
                        r_offset <= (w_wrap && r_ring) ? '0 : w_offset_inc;
                        if (w_wrap) begin
                            r_irq <= 1'b1;
                        end
                        if (w_wrap && !r_ring) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (w_stop_any) begin
                            if (w_fill_after == '0) begin
                                r_done  <= 1'b1;
                                r_irq   <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_FLUSH;
                            end
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_status                = '0;
        o_status[STAT_BUSY]     = (r_state != S_IDLE);
        o_status[STAT_DONE]     = r_done;
        o_status[STAT_OVERFLOW] = r_ovf;
        o_status[STAT_CFG_ERR]  = r_cfg_err;
        o_status[31:8]          = r_offset[23:0];
    end

    assign o_av_address    = r_addr;
    assign o_av_burstcount = r_bcnt;
    assign o_av_write      = r_write;
    assign o_av_writedata  = r_write ? w_head : '0;
    assign o_av_byteenable = 16'hFFFF;
    assign o_irq           = r_irq;

endmodule

// File: tb/tb_line_dma_writer.sv
// Directed scenarios with random data and waitrequest, checked against a
// model where the k-th kept word lands at base + (k mod size).
module tb_line_dma_writer;
    import line_dma_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start, stop, cfg_ring;
    logic [31:0]  cfg_base, cfg_size;
    logic [127:0] px_data;
    logic         px_valid;
    logic [27:0]  av_address;
    logic [7:0]   av_burstcount;
    logic         av_write;
    logic [127:0] av_writedata;
    logic [15:0]  av_byteenable;
    logic         av_waitrequest;
    logic [31:0]  status;
    logic         irq;

    always #5 clk = ~clk;

    line_dma_writer dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_start          (start),
        .i_stop           (stop),
        .i_cfg_ring       (cfg_ring),
        .i_cfg_base       (cfg_base),
        .i_cfg_size       (cfg_size),
        .i_px_data        (px_data),
        .i_px_valid       (px_valid),
        .o_av_address     (av_address),
        .o_av_burstcount  (av_burstcount),
        .o_av_write       (av_write),
        .o_av_writedata   (av_writedata),
        .o_av_byteenable  (av_byteenable),
        .i_av_waitrequest (av_waitrequest),
        .o_status         (status),
        .o_irq            (irq)
    );

    typedef struct {
        logic [27:0] addr;
        logic [7:0]  bcnt;
    } burst_t;

    int n_pass  = 0;
    int n_total = 0;
    int wr_mode = 0;

    burst_t       bursts[$];
    logic [27:0]  beat_addr[$];
    logic [127:0] beat_data[$];
    logic [127:0] exp_q[$];
    int irq_cnt = 0, hold_err = 0, gap_err = 0, cyc = 0;
    int last_beat_cyc = -10, irq_cyc = -10;
    bit          in_burst = 1'b0;
    logic [27:0] cur_addr;
    logic [7:0]  cur_bcnt;
    int          beat_idx = 0;
    int beat0, burst0, irq0, hold0, gap0;

    // Bus monitor: records bursts, accepted beats and irq pulses.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                in_burst = 1'b0;
            end else begin
                if (irq) begin
                    irq_cnt++;
                    irq_cyc = cyc;
                end
                if (av_write) begin
                    if (!in_burst) begin
                        in_burst = 1'b1;
                        cur_addr = av_address;
                        cur_bcnt = av_burstcount;
                        beat_idx = 0;
                        bursts.push_back('{av_address, av_burstcount});
                        if (last_beat_cyc == cyc - 1) gap_err++;
                    end else if (av_address !== cur_addr || av_burstcount !== cur_bcnt) begin
                        hold_err++;
                    end
                    if (!av_waitrequest) begin
                        beat_addr.push_back(cur_addr + 28'(beat_idx));
                        beat_data.push_back(av_writedata);
                        beat_idx++;
                        if (beat_idx == int'(cur_bcnt)) begin
                            in_burst = 1'b0;
                            last_beat_cyc = cyc;
                        end
                    end
                end
            end
        end
    end

    initial begin
        av_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (wr_mode)
                1:       av_waitrequest = 1'($urandom_range(0, 1));
                2:       av_waitrequest = 1'b1;
                default: av_waitrequest = 1'b0;
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        beat0  = beat_addr.size();
        burst0 = bursts.size();
        irq0   = irq_cnt;
        hold0  = hold_err;
        gap0   = gap_err;
        exp_q.delete();
    endtask

    task automatic do_start(input logic [31:0] base, input logic [31:0] size, input logic ring);
        tick();
        cfg_base = base;
        cfg_size = size;
        cfg_ring = ring;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic pulse_stop();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Words beyond 'cap' model drops on a FIFO that cannot drain.
    task automatic push_words(input int n, input int cap, input bit seq, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    px_valid = 1'b0;
                    tick();
                end
            end
            px_valid = 1'b1;
            px_data  = seq ? 128'(i) : {$urandom, $urandom, $urandom, $urandom};
            if (exp_q.size() < cap) exp_q.push_back(px_data);
            tick();
        end
        px_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k = 0;
        while ((beat_addr.size() - beat0) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 128'((beat_addr.size() - beat0) >= n), 128'(1));
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (!(status[STAT_DONE] && !status[STAT_BUSY]) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 128'(status[STAT_DONE] && !status[STAT_BUSY]), 128'(1));
    endtask

    task automatic check_burst(input string tag, input int i, input logic [27:0] addr, input logic [7:0] bcnt);
        if (burst0 + i < bursts.size()) begin
            check({tag, "_addr"}, 128'(bursts[burst0 + i].addr), 128'(addr));
            check({tag, "_bcnt"}, 128'(bursts[burst0 + i].bcnt), 128'(bcnt));
        end else begin
            check({tag, "_missing"}, 128'(bursts.size() - burst0), 128'(i + 1));
        end
    endtask

    task automatic check_run(input string tag, input logic [27:0] base_w, input int size_w,
                             input int n_bursts, input int n_irq, input logic [31:0] exp_status);
        int n_beats = exp_q.size();
        check({tag, "_nbeats"}, 128'(beat_addr.size() - beat0), 128'(n_beats));
        for (int k = 0; k < n_beats && (beat0 + k) < beat_addr.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), 128'(beat_addr[beat0 + k]), 128'(base_w + 28'(k % size_w)));
            check($sformatf("%s_data%0d", tag, k), beat_data[beat0 + k], exp_q[k]);
        end
        check({tag, "_nbursts"}, 128'(bursts.size() - burst0), 128'(n_bursts));
        check({tag, "_irq"}, 128'(irq_cnt - irq0), 128'(n_irq));
        check({tag, "_status"}, 128'(status), 128'(exp_status));
        check({tag, "_hold"}, 128'(hold_err - hold0), 128'(0));
        check({tag, "_gap"}, 128'(gap_err - gap0), 128'(0));
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        cfg_ring = 1'b0;
        cfg_base = '0;
        cfg_size = '0;
        px_data  = '0;
        px_valid = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_write", 128'(av_write), 128'(0));
        check("rst_addr", 128'(av_address), 128'(0));
        check("rst_bcnt", 128'(av_burstcount), 128'(0));
        check("rst_wdata", av_writedata, 128'(0));
        check("rst_status", 128'(status), 128'(0));
        check("rst_irq", 128'(irq), 128'(0));
        check("rst_byteen", 128'(av_byteenable), 128'h FFFF);
        reset_n = 1'b1;
        tick();
        check("rst_status_after", 128'(status), 128'(0));

        // Basic one-shot, two bursts of 8
        begin_test();
        do_start(32'h2000_0000, 32'h100, 1'b0);
        check("t1_busy", 128'(status[STAT_BUSY]), 128'(1));
        push_words(16, 1000, 1'b1, 1'b0);
        wait_done(400, "t1_done");
        check_burst("t1_b0", 0, 28'h200_0000, 8'd8);
        check_burst("t1_b1", 1, 28'h200_0008, 8'd8);
        check_run("t1", 28'h200_0000, 16, 2, 1, 32'h0000_1002);
        check("t1_irq_timing", 128'(irq_cyc - last_beat_cyc), 128'(1));

        // Same transfer with random waitrequest and random input gaps
        begin_test();
        wr_mode = 1;
        do_start(32'h2000_0000, 32'h100, 1'b0);
        push_words(16, 1000, 1'b0, 1'b1);
        wait_done(800, "t2_done");
        wr_mode = 0;
        check_burst("t2_b0", 0, 28'h200_0000, 8'd8);
        check_burst("t2_b1", 1, 28'h200_0008, 8'd8);
        check_run("t2", 28'h200_0000, 16, 2, 1, 32'h0000_1002);

        // Ring wrap on a 6-word buffer, then stop flushes the tail
        begin_test();
        do_start(32'h1000_0000, 32'h60, 1'b1);
        push_words(20, 1000, 1'b0, 1'b0);
        wait_beats(18, 300, "t3_beats18");
        repeat (3) tick();
        check("t3_mid_status", 128'(status), 128'h1);
        check("t3_mid_irq", 128'(irq_cnt - irq0), 128'(3));
        pulse_stop();
        wait_done(300, "t3_done");
        for (int i = 0; i < 3; i++) check_burst($sformatf("t3_b%0d", i), i, 28'h100_0000, 8'd6);
        check_burst("t3_b3", 3, 28'h100_0000, 8'd2);
        check_run("t3", 28'h100_0000, 6, 4, 4, 32'h0000_0202);

        // Overflow while the slave stalls; start while busy is ignored
        begin_test();
        wr_mode = 2;
        tick();
        tick();
        do_start(32'h0800_0000, 32'h1000, 1'b0);
        push_words(40, 32, 1'b0, 1'b0);
        repeat (2) tick();
        check("t4_ovf_status", 128'(status), 128'h5);
        do_start(32'h0, 32'h0, 1'b0);
        check("t4_start_ignored", 128'(status), 128'h5);
        wr_mode = 0;
        wait_beats(32, 400, "t4_beats32");
        repeat (3) tick();
        pulse_stop();
        wait_done(200, "t4_done");
        for (int i = 0; i < 4; i++) check_burst($sformatf("t4_b%0d", i), i, 28'h080_0000 + 28'(8 * i), 8'd8);
        check_run("t4", 28'h080_0000, 256, 4, 1, 32'h0000_2006);

        // Stop mid-burst with 5 extra words queued
        begin_test();
        wr_mode = 2;
        tick();
        tick();
        do_start(32'h0400_0000, 32'h1000, 1'b0);
        push_words(13, 1000, 1'b0, 1'b0);
        tick();
        wr_mode = 0;
        wait_beats(1, 100, "t5_beat1");
        pulse_stop();
        wait_done(200, "t5_done");
        check_burst("t5_b0", 0, 28'h040_0000, 8'd8);
        check_burst("t5_b1", 1, 28'h040_0008, 8'd5);
        check_run("t5", 28'h040_0000, 256, 2, 1, 32'h0000_0D02);

        // Zero-size config, and pixels in IDLE are silently discarded
        begin_test();
        do_start(32'h1234_5670, 32'h8, 1'b0);
        check("t6_cfg_err", 128'(status), 128'h8);
        push_words(10, 0, 1'b0, 1'b0);
        repeat (5) tick();
        check("t6_no_bursts", 128'(bursts.size() - burst0), 128'(0));
        check("t6_no_ovf", 128'(status), 128'h8);
        check("t6_write", 128'(av_write), 128'(0));

        // Asynchronous reset in the middle of a stalled burst
        begin_test();
        wr_mode = 2;
        do_start(32'h3000_0040, 32'h1000, 1'b0);
        push_words(8, 1000, 1'b0, 1'b0);
        repeat (3) tick();
        check("t7_write_pre", 128'(av_write), 128'(1));
        check("t7_addr_pre", 128'(av_address), 128'h300_0004);
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_write", 128'(av_write), 128'(0));
        check("t7_addr", 128'(av_address), 128'(0));
        check("t7_bcnt", 128'(av_burstcount), 128'(0));
        check("t7_wdata", av_writedata, 128'(0));
        check("t7_status", 128'(status), 128'(0));
        check("t7_irq", 128'(irq), 128'(0));
        tick();
        reset_n = 1'b1;
        wr_mode = 0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
